// File: rtl/alu16_pkg.sv
`default_nettype none
//============================================================================
// Module   : alu16_pkg
// Brief    : Opcodes, flag bit positions and FSM states for the ALU front-end.
// Revision : 1.0 - initial release
//============================================================================
package alu16_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu16_core.sv
`default_nettype none
//============================================================================
// Module   : alu16_core
// Brief    : Combinational single-cycle ALU slice: bitwise ops and add/sub.
// Revision : 1.0 - initial release
//============================================================================
module alu16_core
    import alu16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_logic;

    // Subtraction reuses the adder as a + ~b + 1.
    assign w_sub   = (op == OP_SUB);
    assign w_b_eff = w_sub ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_logic[gi] = (op[1:0] == 2'b00) ? (a[gi] & b[gi]) :
                                 (op[1:0] == 2'b01) ? (a[gi] | b[gi]) :
                                 (op[1:0] == 2'b10) ? (a[gi] ^ b[gi]) :
                                                      ~a[gi];
        end
    endgenerate

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                y = w_logic;
            end
            OP_ADD, OP_SUB: begin
                y = w_sum[WIDTH-1:0];
                c = w_sum[WIDTH];
                v = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                y = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu16_arbiter.sv
`default_nettype none
//============================================================================
// Module   : alu16_arbiter
// Brief    : Round-robin two-requester front-end for the shared 16-bit ALU.
// Revision : 1.0 - initial release
//============================================================================
module alu16_arbiter
    import alu16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_id,
    output logic             busy
);

    localparam int c_CNT_W = 4;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_rr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_id;
    logic [WIDTH-1:0]   r_acc;
    logic               r_c;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [3:0]         r_rsp_flags;
    logic               r_rsp_id;

    logic               w_grant_valid;
    logic               w_grant_id;
    logic               w_accept;
    logic [2:0]         w_sel_op;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_is_shift;
    logic               w_shift_step;
    logic [WIDTH-1:0]   w_core_y;
    logic               w_core_c;
    logic               w_core_v;
    logic [WIDTH-1:0]   w_result;
    logic               w_res_c;
    logic               w_res_v;
    logic [3:0]         w_flags;

    // A lone requester wins outright; the pointer only breaks ties.
    assign w_grant_valid = req0_valid | req1_valid;
    assign w_grant_id    = (req0_valid & req1_valid) ? r_rr : req1_valid;
    assign w_accept      = rst_n & (r_state == IDLE) & w_grant_valid;

    assign req0_ready = w_accept & ~w_grant_id;
    assign req1_ready = w_accept &  w_grant_id;

    assign w_sel_op = w_grant_id ? req1_op : req0_op;
    assign w_sel_a  = w_grant_id ? req1_a  : req0_a;
    assign w_sel_b  = w_grant_id ? req1_b  : req0_b;

    assign w_is_shift   = is_shift(r_op);
    assign w_shift_step = w_is_shift && (r_cnt != '0);

    alu16_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (r_op),
        .a  (r_a),
        .b  (r_b),
        .y  (w_core_y),
        .c  (w_core_c),
        .v  (w_core_v)
    );

    assign w_result = w_is_shift ? r_acc : w_core_y;
    assign w_res_c  = w_is_shift ? r_c   : w_core_c;
    assign w_res_v  = w_is_shift ? 1'b0  : w_core_v;

    always_comb begin
        w_flags        = '0;
        w_flags[FLG_N] = w_result[WIDTH-1];
        w_flags[FLG_Z] = (w_result == '0);
        w_flags[FLG_C] = w_res_c;
        w_flags[FLG_V] = w_res_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                if (!w_shift_step) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= 1'b0;
            r_cnt       <= '0;
            r_op        <= OP_AND;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= 1'b0;
            r_acc       <= '0;
            r_c         <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_id    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_sel_op;
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_id  <= w_grant_id;
                        r_rr  <= ~w_grant_id;
                        r_cnt <= is_shift(w_sel_op) ? w_sel_b[c_CNT_W-1:0] : '0;
                        r_acc <= w_sel_a;
                        r_c   <= 1'b0;
                    end
                end
                EXEC: begin
                    if (w_shift_step) begin
                        if (r_op == OP_SHL) begin
                            r_c   <= r_acc[WIDTH-1];
                            r_acc <= {r_acc[WIDTH-2:0], 1'b0};
                        end else begin
                            r_c   <= r_acc[0];
                            r_acc <= {1'b0, r_acc[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_data  <= w_result;
                        r_rsp_flags <= w_flags;
                        r_rsp_id    <= r_id;
                    end
                end
                RESP: begin
                    // Result registers settle one cycle before valid is raised.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu16_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_alu16_arbiter
// Brief    : Scoreboard bench for alu16_arbiter with a behavioural ALU model.
// Revision : 1.0 - initial release
//============================================================================
module tb_alu16_arbiter;
    import alu16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;
        logic        id;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp, n_bad, cyc;
    int   rdy_mode;
    logic model_rr;
    logic seen;
    logic [20:0] snap;

    alu16_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU from the opcode table, using plain integer arithmetic.
    function automatic exp_t ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        r;
        int          sa, sb, s, n;
        logic [16:0] wide;
        logic        c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b[3:0]);
        c  = 1'b0;
        v  = 1'b0;
        r.data = 16'h0;
        case (op)
            3'd0: r.data = a & b;
            3'd1: r.data = a | b;
            3'd2: r.data = a ^ b;
            3'd3: r.data = ~a;
            3'd4: begin
                wide = {1'b0, a} + {1'b0, b};
                r.data = wide[15:0]; c = wide[16];
                s = sa + sb; v = (s > 32767) || (s < -32768);
            end
            3'd5: begin
                wide = {1'b0, a} + {1'b0, ~b} + 17'd1;
                r.data = wide[15:0]; c = wide[16];
                s = sa - sb; v = (s > 32767) || (s < -32768);
            end
            3'd6: begin r.data = a << n; c = (n == 0) ? 1'b0 : a[16-n]; end
            default: begin r.data = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
        endcase
        r.flags = {r.data[15], (r.data == 16'h0), c, v};
        r.id    = 1'b0;
        r.due   = 0;
        return r;
    endfunction

    task automatic send(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ((id && req1_ready) || (!id && req0_ready)) begin
                @(posedge clk); #1;
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 600 && sb_q.size() != 0; k++) @(negedge clk);
        check("drain", sb_q.size(), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; rdy_mode = 0; model_rr = 1'b0; seen = 1'b0; snap = '0;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 16'h0; req0_b = 16'h0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 16'h0; req1_b = 16'h0;

        fork
            forever begin
                @(posedge clk); #1;
                rsp_ready = (rdy_mode == 0) ? 1'b1 :
                            (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            begin : mon
                logic wid;
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        check("reset_outputs", {7'd0, rsp_valid, rsp_data, rsp_flags, rsp_id,
                              busy, req0_ready, req1_ready}, 32'd0);
                        sb_q.delete(); seen = 1'b0; model_rr = 1'b0;
                    end else begin
                        if (busy) check("ready_while_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
                        if (!busy && (req0_valid || req1_valid)) begin
                            wid = (req0_valid && req1_valid) ? model_rr : req1_valid;
                            check("grant", {30'd0, req1_ready, req0_ready}, wid ? 32'd2 : 32'd1);
                            e = wid ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
                            e.id  = wid;
                            e.due = cyc + 3 + ((wid ? req1_op[2:1] : req0_op[2:1]) == 2'b11 ?
                                               int'(wid ? req1_b[3:0] : req0_b[3:0]) : 0);
                            model_rr = ~wid;
                            sb_q.push_back(e);
                        end
                        if (rsp_valid) begin
                            if (sb_q.size() == 0) begin
                                check("spurious_rsp", 32'd1, 32'd0);
                            end else begin
                                if (!seen) begin
                                    seen = 1'b1;
                                    snap = {rsp_id, rsp_flags, rsp_data};
                                    check("latency", cyc, sb_q[0].due);
                                    check("rsp_data", {16'd0, rsp_data}, {16'd0, sb_q[0].data});
                                    check("rsp_flags", {28'd0, rsp_flags}, {28'd0, sb_q[0].flags});
                                    check("rsp_id", {31'd0, rsp_id}, {31'd0, sb_q[0].id});
                                end else begin
                                    check("rsp_stable", {11'd0, rsp_id, rsp_flags, rsp_data}, {11'd0, snap});
                                end
                                if (rsp_ready) begin
                                    void'(sb_q.pop_front());
                                    seen = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Contention straight out of reset: order must be 0,1,0,1.
        fork
            begin send(0, OP_ADD, 16'h1111, 16'h2222); send(0, OP_ADD, 16'hFFFF, 16'h0001); end
            begin send(1, OP_ADD, 16'h0100, 16'h0200); send(1, OP_ADD, 16'h8000, 16'h8000); end
        join
        drain();

        send(0, OP_XOR, 16'hF0F0, 16'h0FF0);
        send(0, OP_ADD, 16'h7FFF, 16'h0001);
        send(1, OP_SUB, 16'h0005, 16'h0005);
        send(0, OP_SHL, 16'h8001, 16'h0004);
        send(1, OP_SHR, 16'h0003, 16'h0001);
        send(0, OP_SHL, 16'hA5C3, 16'h0000);
        send(1, OP_NOT, 16'h1234, 16'h0000);
        drain();

        // Backpressure: response held, req1 waits, then accepted next cycle.
        rdy_mode = 2;
        @(posedge clk); #1;
        send(0, OP_ADD, 16'h4000, 16'h4000);
        req1_valid = 1'b1; req1_op = OP_OR; req1_a = 16'h00F0; req1_b = 16'h0F00;
        for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("bp_held_ready", {31'd0, req1_ready}, 32'd0);
        rdy_mode = 0;
        for (int k = 0; k < 50 && !(rsp_valid && rsp_ready); k++) @(negedge clk);
        @(negedge clk);
        check("bp_accept_next", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 80; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            if (sel == 2) begin
                fork
                    send(0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
                    send(1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
                join
            end else begin
                send(1'(sel), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        drain();

        // Reset during a long shift discards it; arbitration restarts at 0.
        send(0, OP_SHL, 16'h1234, 16'h000F);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle", {30'd0, rsp_valid, busy}, 32'd0);
        @(posedge clk); #1;
        fork
            send(1, OP_AND, 16'hFF0F, 16'h0FFF);
            send(0, OP_SUB, 16'h0000, 16'h0001);
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
